// File: rtl/ws2811_frame_buffer_if.sv
// Host write/commit port and strip-driver read port of the WS2811 frame buffer.
// The host and driver side uses master; the frame buffer uses slave.
interface ws2811_frame_buffer_if #(
  parameter int NUM_LEDS = 4
);
  localparam int ADDR_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_red;
  logic [7:0]        wr_green;
  logic [7:0]        wr_blue;
  logic [7:0]        brightness;
  logic              commit;
  logic              wr_ready;
  logic              swap_pending;
  logic              frame_swapped;
  logic              data_request;
  logic [ADDR_W-1:0] address;
  logic [7:0]        red_out;
  logic [7:0]        green_out;
  logic [7:0]        blue_out;

  modport master (
    output wr_en, wr_addr, wr_red, wr_green, wr_blue, brightness, commit,
    output data_request, address,
    input  wr_ready, swap_pending, frame_swapped,
    input  red_out, green_out, blue_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_red, wr_green, wr_blue, brightness, commit,
    input  data_request, address,
    output wr_ready, swap_pending, frame_swapped,
    output red_out, green_out, blue_out
  );
endinterface

// File: rtl/ws2811_frame_buffer.sv
// Double-buffered WS2811 colour store: brightness-scaled host writes go to the back bank,
// banks swap on commit at the next frame boundary, the driver reads the front bank.
module ws2811_frame_buffer #(
  parameter int NUM_LEDS = 4
) (
  input logic                  clk,
  input logic                  reset,
  ws2811_frame_buffer_if.slave bus
);
  localparam int ADDR_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int IDX_W  = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LEDS_W = IDX_W'(NUM_LEDS);

  // NOTE: the RAM has no reset; its contents mean nothing until the host writes a frame.
  logic [23:0] mem_q [2*NUM_LEDS];

  logic              s1_valid_q, s1_valid_d;
  logic              s1_commit_q, s1_commit_d;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [23:0]       s1_rgb_q;
  logic              s2_valid_q;
  logic              s2_commit_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic [23:0]       s2_rgb_q;

  logic        front_sel_q, front_sel_d;
  logic        swap_pending_q, swap_pending_d;
  logic        frame_swapped_q, frame_swapped_d;
  logic [23:0] rgb_q, rgb_d;
  logic [23:0] rd_data;
  logic        wr_ready;
  logic        boundary;
  logic        swap_now;
  logic        read_bank;
  logic [15:0] scale;

  // Bank 0 occupies entries [0, NUM_LEDS), bank 1 follows it.
  function automatic logic [IDX_W-1:0] mem_idx(input logic bank, input logic [ADDR_W-1:0] addr);
    return bank ? (IDX_W'(addr) + LEDS_W) : IDX_W'(addr);
  endfunction

  // c * (brightness + 1) >> 8: 255 is identity, 0 blanks the channel.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [15:0] s);
    return 8'((16'(c) * s) >> 8);
  endfunction

  always_comb begin
    // NOTE: every combinational output is assigned a default first, so no path infers a latch.
    wr_ready        = !swap_pending_q && !s1_commit_q && !s2_commit_q;
    boundary        = bus.data_request && (bus.address == '0);
    swap_now        = boundary && swap_pending_q;
    read_bank       = front_sel_q ^ swap_now;
    scale           = 16'(bus.brightness) + 16'd1;
    s1_valid_d      = bus.wr_en && wr_ready && (IDX_W'(bus.wr_addr) < LEDS_W);
    s1_commit_d     = bus.commit && wr_ready;
    front_sel_d     = front_sel_q ^ swap_now;
    frame_swapped_d = swap_now;
    swap_pending_d  = swap_pending_q;
    if (swap_now) begin
      swap_pending_d = 1'b0;
    end else if (s2_commit_q) begin
      // A commit landing on a boundary cycle waits for the following boundary.
      swap_pending_d = 1'b1;
    end
    rd_data = '0;
    if (IDX_W'(bus.address) < LEDS_W) begin
      rd_data = mem_q[mem_idx(read_bank, bus.address)];
    end
    rgb_d = bus.data_request ? rd_data : rgb_q;
  end

  // NOTE: state registers use non-blocking assignments so each samples its pre-edge inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q      <= 1'b0;
      s1_commit_q     <= 1'b0;
      s2_valid_q      <= 1'b0;
      s2_commit_q     <= 1'b0;
      front_sel_q     <= 1'b0;
      swap_pending_q  <= 1'b0;
      frame_swapped_q <= 1'b0;
      rgb_q           <= '0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_commit_q     <= s1_commit_d;
      s2_valid_q      <= s1_valid_q;
      s2_commit_q     <= s1_commit_q;
      front_sel_q     <= front_sel_d;
      swap_pending_q  <= swap_pending_d;
      frame_swapped_q <= frame_swapped_d;
      rgb_q           <= rgb_d;
    end
  end

  // Write datapath; qualified by the valid flags above, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_addr_q <= bus.wr_addr;
    s1_rgb_q  <= {scale_ch(bus.wr_red, scale), scale_ch(bus.wr_green, scale),
                  scale_ch(bus.wr_blue, scale)};
    s2_addr_q <= s1_addr_q;
    s2_rgb_q  <= s1_rgb_q;
  end

  always_ff @(posedge clk) begin
    if (!reset && s2_valid_q) begin
      mem_q[mem_idx(!front_sel_q, s2_addr_q)] <= s2_rgb_q;
    end
  end

  assign bus.wr_ready      = wr_ready;
  assign bus.swap_pending  = swap_pending_q;
  assign bus.frame_swapped = frame_swapped_q;
  assign bus.red_out       = rgb_q[23:16];
  assign bus.green_out     = rgb_q[15:8];
  assign bus.blue_out      = rgb_q[7:0];
endmodule

// File: tb/tb_ws2811_frame_buffer.sv
// Scoreboard bench for ws2811_frame_buffer: directed host frames and driver reads,
// expected colours queued at request time and compared by a separate monitor.
`timescale 1ns/1ps
module tb_ws2811_frame_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ws2811_frame_buffer_if #(.NUM_LEDS(4)) bus ();
  ws2811_frame_buffer #(.NUM_LEDS(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Non-power-of-two instance, so wr_addr == NUM_LEDS is representable.
  ws2811_frame_buffer_if #(.NUM_LEDS(3)) bus3 ();
  ws2811_frame_buffer #(.NUM_LEDS(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] exp_q [$];
  logic [23:0] held = 24'h0;
  logic        mon_en = 1'b0;
  logic        req_s;
  logic        rst_s;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %06h, expected %06h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {23'b0, act}, {23'b0, exp});
  endtask

  // Monitor: one response per accepted request, otherwise the outputs must hold.
  always begin
    @(posedge clk);
    req_s = bus.data_request;
    rst_s = reset;
    @(negedge clk);
    if (mon_en) begin
      if (rst_s) begin
        held = 24'h0;
        check("rst_rgb", {bus.red_out, bus.green_out, bus.blue_out}, 24'h0);
      end else if (req_s) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rd_unexpected: got %06h, expected no response at %0t",
                   {bus.red_out, bus.green_out, bus.blue_out}, $time);
        end else begin
          held = exp_q.pop_front();
          check("rd_data", {bus.red_out, bus.green_out, bus.blue_out}, held);
        end
      end else begin
        check("rd_hold", {bus.red_out, bus.green_out, bus.blue_out}, held);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.data_request = 1'b0;
    bus.wr_en        = 1'b0;
    bus.commit       = 1'b0;
    repeat (n) tick();
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic [7:0] br, input logic cmt);
    bus.wr_en      = 1'b1;
    bus.wr_addr    = a;
    bus.wr_red     = r;
    bus.wr_green   = g;
    bus.wr_blue    = b;
    bus.brightness = br;
    bus.commit     = cmt;
    tick();
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
  endtask

  task automatic host_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  // Commit, then swap_pending must be up exactly three edges after the commit cycle.
  task automatic commit_wait();
    host_commit();
    tick();
    tick();
    check_bit("pending_rise", bus.swap_pending, 1'b1);
  endtask

  task automatic req(input logic [1:0] a, input logic [23:0] exp);
    bus.data_request = 1'b1;
    bus.address      = a;
    exp_q.push_back(exp);
    tick();
    bus.data_request = 1'b0;
  endtask

  task automatic run_frame(input logic [23:0] base, input logic expect_swap);
    for (int i = 0; i < 4; i++) begin
      req(2'(i), base + 24'(i));
      if (i == 0) check_bit("frame_swapped", bus.frame_swapped, expect_swap);
      idle(1);
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_red = '0; bus.wr_green = '0;
    bus.wr_blue = '0; bus.brightness = '0; bus.commit = 1'b0;
    bus.data_request = 1'b0; bus.address = '0;
    bus3.wr_en = 1'b0; bus3.wr_addr = '0; bus3.wr_red = '0; bus3.wr_green = '0;
    bus3.wr_blue = '0; bus3.brightness = '0; bus3.commit = 1'b0;
    bus3.data_request = 1'b0; bus3.address = '0;

    // Reset state
    reset = 1'b1;
    repeat (2) tick();
    check_bit("rst_pending", bus.swap_pending, 1'b0);
    check_bit("rst_swapped", bus.frame_swapped, 1'b0);
    check("rst_rgb_init", {bus.red_out, bus.green_out, bus.blue_out}, 24'h0);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();
    check_bit("ready_after_rst", bus.wr_ready, 1'b1);

    // First frame at full brightness, commit timing, swap on address 0
    for (int i = 0; i < 4; i++) host_write(2'(i), 8'h10, 8'h20, 8'h30 + 8'(i), 8'd255, 1'b0);
    host_commit();
    check_bit("ready_s1_commit", bus.wr_ready, 1'b0);
    tick();
    check_bit("pending_not_yet", bus.swap_pending, 1'b0);
    tick();
    check_bit("pending_3cyc", bus.swap_pending, 1'b1);
    check_bit("ready_pending", bus.wr_ready, 1'b0);
    req(2'd0, 24'h102030);
    check_bit("swapped_pulse", bus.frame_swapped, 1'b1);
    check_bit("pending_clear", bus.swap_pending, 1'b0);
    check_bit("ready_restored", bus.wr_ready, 1'b1);
    idle(1);
    check_bit("swapped_one_cyc", bus.frame_swapped, 1'b0);
    req(2'd1, 24'h102031);
    req(2'd2, 24'h102032);
    idle(3);
    req(2'd3, 24'h102033);
    idle(2);

    // Brightness sweep on LED 0: 0, 127, 255
    host_write(2'd0, 8'd200, 8'd100, 8'd1, 8'd0, 1'b0);
    commit_wait();
    req(2'd0, 24'h000000);
    idle(1);
    host_write(2'd0, 8'd200, 8'd100, 8'd1, 8'd127, 1'b0);
    commit_wait();
    req(2'd0, 24'h643200);
    idle(1);
    host_write(2'd0, 8'd200, 8'd100, 8'd1, 8'd255, 1'b0);
    commit_wait();
    req(2'd0, 24'hC86401);
    idle(1);

    // Tearing: uncommitted writes stay invisible for a whole frame
    for (int i = 0; i < 4; i++) host_write(2'(i), 8'h0A, 8'h0B, 8'(i), 8'd255, 1'b0);
    commit_wait();
    run_frame(24'h0A0B00, 1'b1);
    for (int i = 0; i < 4; i++) host_write(2'(i), 8'h5A, 8'h5B, 8'h50 + 8'(i), 8'd255, 1'b0);
    idle(2);
    run_frame(24'h0A0B00, 1'b0);
    check_bit("no_commit_no_pending", bus.swap_pending, 1'b0);
    commit_wait();
    run_frame(24'h5A5B50, 1'b1);

    // Write+commit together; pending rises on a boundary cycle, so the swap waits a frame
    host_write(2'd0, 8'h77, 8'h88, 8'h99, 8'd255, 1'b1);
    check_bit("ready_wr_commit", bus.wr_ready, 1'b0);
    tick();
    req(2'd0, 24'h5A5B50);
    check_bit("pending_at_boundary", bus.swap_pending, 1'b1);
    check_bit("no_swap_at_boundary", bus.frame_swapped, 1'b0);
    idle(1);
    req(2'd1, 24'h5A5B51);
    idle(1);
    req(2'd0, 24'h778899);
    check_bit("late_swap", bus.frame_swapped, 1'b1);
    idle(1);
    req(2'd1, 24'h0A0B01);
    idle(1);

    // Writes while swap_pending are dropped
    commit_wait();
    host_write(2'd1, 8'hEE, 8'hEE, 8'hEE, 8'd255, 1'b0);
    check_bit("ready_low_pending", bus.wr_ready, 1'b0);
    idle(3);
    run_frame(24'h5A5B50, 1'b1);
    check_bit("pending_after_frame", bus.swap_pending, 1'b0);

    // Reset with a commit pending: commit lost, front bank back to 0
    commit_wait();
    req(2'd0, 24'h778899);
    idle(1);
    commit_wait();
    reset = 1'b1;
    tick();
    check_bit("rst_mid_pending", bus.swap_pending, 1'b0);
    check_bit("rst_mid_swapped", bus.frame_swapped, 1'b0);
    check_bit("rst_mid_ready", bus.wr_ready, 1'b1);
    reset = 1'b0;
    tick();
    req(2'd0, 24'h5A5B50);
    check_bit("rst_no_swap", bus.frame_swapped, 1'b0);
    check_bit("rst_commit_lost", bus.swap_pending, 1'b0);

    // Back-to-back driver reads
    req(2'd1, 24'h5A5B51);
    req(2'd2, 24'h5A5B52);
    req(2'd3, 24'h5A5B53);
    idle(3);

    // Out-of-range write dropped while its commit proceeds; out-of-range read gives 0
    bus3.wr_en = 1'b1; bus3.wr_addr = 2'd0; bus3.brightness = 8'd255;
    bus3.wr_red = 8'h12; bus3.wr_green = 8'h34; bus3.wr_blue = 8'h56;
    tick();
    bus3.wr_addr = 2'd3; bus3.wr_red = 8'hFF; bus3.wr_green = 8'hFF; bus3.wr_blue = 8'hFF;
    bus3.commit = 1'b1;
    tick();
    bus3.wr_en = 1'b0; bus3.commit = 1'b0;
    tick();
    tick();
    check_bit("oor_commit_pending", bus3.swap_pending, 1'b1);
    bus3.data_request = 1'b1; bus3.address = 2'd0;
    tick();
    check("oor_led0", {bus3.red_out, bus3.green_out, bus3.blue_out}, 24'h123456);
    check_bit("oor_swapped", bus3.frame_swapped, 1'b1);
    bus3.address = 2'd3;
    tick();
    check("oor_read", {bus3.red_out, bus3.green_out, bus3.blue_out}, 24'h000000);
    bus3.data_request = 1'b0;
    idle(2);

    check("sb_drain", 24'(exp_q.size()), 24'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
